// File: rtl/knn_local_sp_arbiter.sv
// Round-robin arbiter sharing one single-port local buffer between the load
// engine (writes) and the partial-kNN compute engine (reads), with credited responses.
module knn_local_sp_arbiter #(
    parameter int DataWidth    = 256,
    parameter int AddressWidth = 11,
    parameter int RdLat        = 2,
    parameter int RespDepth    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [AddressWidth-1:0]   wr_addr,
    input  logic [DataWidth-1:0]      wr_data,
    input  logic                      rd_valid,
    output logic                      rd_ready,
    input  logic [AddressWidth-1:0]   rd_addr,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DataWidth-1:0]      rsp_data,
    output logic [AddressWidth-1:0]   mem_address,
    output logic                      mem_ce,
    output logic                      mem_we,
    output logic [DataWidth-1:0]      mem_d,
    input  logic [DataWidth-1:0]      mem_q,
    output logic [$clog2(RespDepth):0] credits_used,
    output logic                      idle
);
    localparam int CntW = $clog2(RespDepth) + 1;
    localparam int PtrW = $clog2(RespDepth);

    typedef enum logic {GRANT_RD = 1'b0, GRANT_WR = 1'b1} grant_t;

    grant_t                last_grant;
    logic [RdLat-1:0]      vld_pipe;
    logic [DataWidth-1:0]  fifo_mem [RespDepth];
    logic [PtrW-1:0]       wptr, rptr;
    logic [CntW-1:0]       fifo_count;
    logic                  rd_eligible, grant_wr, grant_rd, push, pop;

    // Credits cover both in-flight reads and queued responses, so the FIFO can never overflow.
    assign rd_eligible = !reset && rd_valid && (credits_used < CntW'(RespDepth));

    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (!reset) begin
            if (wr_valid && rd_eligible) begin
                grant_wr = (last_grant == GRANT_RD);
                grant_rd = (last_grant == GRANT_WR);
            end else begin
                grant_wr = wr_valid;
                grant_rd = rd_eligible;
            end
        end
    end

    assign wr_ready    = grant_wr;
    assign rd_ready    = grant_rd;
    assign mem_ce      = grant_wr | grant_rd;
    assign mem_we      = grant_wr;
    assign mem_d       = wr_data;
    assign mem_address = grant_wr ? wr_addr : (grant_rd ? rd_addr : '0);

    assign push      = !reset && vld_pipe[RdLat-1];
    assign rsp_valid = !reset && (fifo_count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = fifo_mem[rptr];
    assign idle      = (credits_used == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant   <= GRANT_RD;
            vld_pipe     <= '0;
            wptr         <= '0;
            rptr         <= '0;
            fifo_count   <= '0;
            credits_used <= '0;
        end else begin
            if (grant_wr)      last_grant <= GRANT_WR;
            else if (grant_rd) last_grant <= GRANT_RD;
            vld_pipe[0] <= grant_rd;
            for (int i = 1; i < RdLat; i++) vld_pipe[i] <= vld_pipe[i-1];
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            fifo_count   <= fifo_count + CntW'(push) - CntW'(pop);
            credits_used <= credits_used + CntW'(grant_rd) - CntW'(pop);
            assert (!(push && !pop && fifo_count == CntW'(RespDepth)));
        end
    end

    // Response storage carries no reset; only the pointers qualify it.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr] <= mem_q;
    end
endmodule

// File: tb/tb_knn_local_sp_arbiter.sv
// Randomized bench for knn_local_sp_arbiter: behavioural URAM plus a
// transaction-level model (shadow memory, response queue with due cycles).
module tb_knn_local_sp_arbiter;
    localparam int DW = 256, AW = 11, RDL = 2, DEPTH = 4;

    logic clk = 0, reset;
    logic wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid, rsp_ready;
    logic [AW-1:0] wr_addr, rd_addr, mem_address;
    logic [DW-1:0] wr_data, rsp_data, mem_d, mem_q;
    logic mem_ce, mem_we, idle;
    logic [2:0] credits_used;

    always #5 clk = ~clk;

    knn_local_sp_arbiter #(.DataWidth(DW), .AddressWidth(AW), .RdLat(RDL), .RespDepth(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mem_address(mem_address), .mem_ce(mem_ce), .mem_we(mem_we), .mem_d(mem_d), .mem_q(mem_q),
        .credits_used(credits_used), .idle(idle));

    // Single-port memory with RDL-cycle read latency
    bit [DW-1:0] mem_arr [2048];
    bit [DW-1:0] q_stage [RDL];
    assign mem_q = q_stage[RDL-1];
    always @(posedge clk) begin
        if (mem_ce && mem_we) mem_arr[mem_address] <= mem_d;
        if (mem_ce && !mem_we) q_stage[0] <= mem_arr[mem_address];
        for (int i = 1; i < RDL; i++) q_stage[i] <= q_stage[i-1];
    end

    // Reference model state
    typedef struct { logic [DW-1:0] data; int due; } rsp_t;
    rsp_t        exp_q[$];
    bit [DW-1:0] shadow [2048];
    int          m_credits = 0;
    bit          m_last_wr = 0;
    int          cyc = 0, n_chk = 0, n_fail = 0, n_rd_acc = 0, n_pops = 0;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // One clock cycle: drive, check against the model at negedge, advance model.
    task automatic step(input bit rst, input bit wv, input bit rv, input bit rr,
                        input int wa, input int ra, input logic [DW-1:0] wd);
        bit gw, gr, elig, erv, epop;
        int eaddr;
        reset = rst; wr_valid = wv; rd_valid = rv; rsp_ready = rr;
        wr_addr = AW'(wa); rd_addr = AW'(ra); wr_data = wd;
        @(negedge clk);
        elig = !rst && rv && (m_credits < DEPTH);
        gw = 0; gr = 0;
        if (!rst) begin
            if (wv && elig) begin gw = !m_last_wr; gr = m_last_wr; end
            else begin gw = wv; gr = elig; end
        end
        eaddr = gw ? wa : (gr ? ra : 0);
        erv = !rst && exp_q.size() > 0 && exp_q[0].due <= cyc;
        epop = erv && rr;
        chk("wr_ready", DW'(wr_ready), DW'(gw));
        chk("rd_ready", DW'(rd_ready), DW'(gr));
        chk("mem_ce", DW'(mem_ce), DW'(gw | gr));
        chk("mem_we", DW'(mem_we), DW'(gw));
        chk("mem_address", DW'(mem_address), DW'(eaddr));
        if (gw) chk("mem_d", mem_d, wd);
        chk("credits_used", DW'(credits_used), DW'(m_credits));
        chk("idle", DW'(idle), DW'(m_credits == 0));
        chk("rsp_valid", DW'(rsp_valid), DW'(erv));
        if (erv) chk("rsp_data", rsp_data, exp_q[0].data);
        if (rd_ready) n_rd_acc++;
        if (epop) n_pops++;
        if (rst) begin
            exp_q.delete();
            m_credits = 0;
            m_last_wr = 0;
        end else begin
            if (gw) begin shadow[wa] = wd; m_last_wr = 1; end
            if (gr) begin exp_q.push_back('{shadow[ra], cyc + RDL + 1}); m_last_wr = 0; end
            if (epop) void'(exp_q.pop_front());
            m_credits = m_credits + int'(gr) - int'(epop);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        reset = 1; wr_valid = 0; rd_valid = 0; rsp_ready = 0;
        wr_addr = 0; rd_addr = 0; wr_data = 0;
        @(posedge clk); #1;
        step(1, 0, 0, 0, 0, 0, '0);
        step(1, 0, 0, 0, 0, 0, '0);
        // Idle after reset
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, '0);

        // Write pattern then read it back
        step(0, 1, 0, 1, 5, 0, {32{8'hA5}});
        step(0, 0, 1, 1, 0, 5, '0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0, '0);

        // Contention: alternation starting with write
        for (int i = 0; i < 8; i++) step(0, 1, 1, 1, 16 + i, 16 + i, rnd_word());
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, 0, '0);

        // Credit exhaustion with rsp_ready low
        for (int i = 0; i < 32; i++) step(0, 1, 0, 1, i, 0, rnd_word());
        n_rd_acc = 0;
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, i, '0);
        chk("fill_accepts", DW'(n_rd_acc), DW'(4));
        chk("fill_credits", DW'(credits_used), DW'(4));
        for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 0, 4 + i, '0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0, 0, '0);

        // Reset with reads in flight
        step(0, 0, 1, 1, 0, 3, '0);
        step(0, 0, 1, 1, 0, 4, '0);
        step(1, 0, 0, 1, 0, 0, '0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0, '0);
        step(0, 0, 1, 1, 0, 7, '0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0, '0);

        // Back-to-back reads 0..7
        n_pops = 0;
        for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 0, i, '0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, 0, '0);
        chk("b2b_responses", DW'(n_pops), DW'(8));

        // Randomized traffic with occasional reset
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 15), rnd_word());
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0, 0, '0);
        chk("final_idle", DW'(idle), DW'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
